cache_wb_dm: RTL and testbench
==============================

Name: cache_wb_dm

Overview:
- Parametrised, direct-mapped, write-back, write-allocate data cache between the processor load/store path and word-addressed main memory.
- Successor to the fixed 16-bit cache: adds configurable widths and line size, multi-word lines, and dirty-line write-back.
- Uses a req/ready/done handshake on the processor side and a req/ack handshake on the memory side, sequenced by an FSM.

Parameters:
- ADDR_W, 16: word-address width.
- DATA_W, 16: data word width.
- INDEX_W, 6: line index bits; 2^INDEX_W lines.
- OFFSET_W, 2: word-in-line bits; 2^OFFSET_W words per line.
- Tag width = ADDR_W-INDEX_W-OFFSET_W; default 8.

Ports:
- clk_100  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pro_req  in  1  processor request; sampled only when pro_ready=1.
- pro_we  in  1  1=store, 0=load.
- addr_in  in  ADDR_W  word address, split {tag,index,offset}.
- data_in_from_pro  in  DATA_W  store data.
- pro_ready  out  1  cache can accept a request.
- pro_done  out  1  one-cycle completion pulse.
- data_out_to_pro  out  DATA_W  load data; valid while pro_done=1, held afterwards.
- hit  out  1  one-cycle pulse with pro_done when the access hit without a refill.
- mem_req  out  1  memory transfer request.
- mem_we  out  1  1=write-back word, 0=refill read.
- addr_out  out  ADDR_W  memory word address.
- data_out_to_mem  out  DATA_W  write-back data.
- data_in_from_mem  in  DATA_W  refill data; sampled when mem_ack=1.
- mem_ack  in  1  word transfer completes this cycle.

Behaviour:
- Reset (async, rst_n=0):
  - All valid and dirty bits cleared; state IDLE.
  - pro_ready=1.
  - pro_done, hit, mem_req, mem_we = 0.
  - addr_out, data_out_to_mem, data_out_to_pro = 0.
  - Data and tag arrays are not reset.
  - Reset mid-transfer abandons the operation immediately; mem_req drops asynchronously.
- States: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
- IDLE:
  - pro_ready=1.
  - On an edge with pro_req=1: latch addr_in, pro_we and data_in_from_pro; go to LOOKUP.
  - pro_ready=0 in every other state.
- LOOKUP:
  - Hit = valid[index] && tag match.
  - Hit, load: data_out_to_pro <= word at offset.
  - Hit, store: write the word and set dirty.
  - Both hit cases go to RESPOND with hit=1.
  - Miss with valid && dirty: go to WRITEBACK, word counter=0.
  - Otherwise (miss, not dirty-valid): go to REFILL, word counter=0.
- WRITEBACK:
  - mem_req=1, mem_we=1.
  - addr_out = {stored tag, index, counter}; data_out_to_mem = that word.
  - Outputs stay stable until mem_ack.
  - On mem_ack, counter increments and the next word is presented the following cycle; mem_req may stay high.
  - After the ack for the last word, clear dirty and go to REFILL, counter=0.
- REFILL:
  - mem_req=1, mem_we=0, addr_out = {new tag, index, counter}.
  - On mem_ack, write data_in_from_mem into that word.
  - After the last ack: tag <= new tag, valid=1, dirty=0; go to LOOKUP with a miss flag set so hit stays 0.
  - The second LOOKUP then hits and completes the access; for a store it sets dirty.
- RESPOND:
  - pro_done=1 for exactly one cycle; hit=1 only if the first lookup hit.
  - Next state IDLE.
- Latency:
  - Hit: pro_done asserted 2 cycles after the request edge; new request accepted on the 3rd edge.
  - Clean miss: 2 + N×(ack wait) + 1 cycles, N = 2^OFFSET_W.
  - Dirty miss adds N write-back transfers.
- mem_ack while mem_req=0 is ignored.
- Counter wraps at 2^OFFSET_W - 1; the wrap ends the phase.
- pro_req while pro_ready=0 is ignored; the processor must hold the request or re-issue it.

Optional Feature:
- Macro CACHE_STATS_EN.
- Defined: adds outputs hit_count and miss_count, each 32 bits.
  - hit_count increments on each RESPOND with hit=1; miss_count on each RESPOND with hit=0.
  - Both saturate at all-ones and reset to 0.
- Undefined: no ports and no logic for the counters.

Test Plan:
1. Post-reset load at addr 16'hF005 (tag F0, index 1, offset 1), memory returns 16'hA0A0+word → 4 reads at addr_out F004..F007; data_out_to_pro=16'hA0A1; hit=0.
2. Repeat load 16'hF005 → pro_done 2 cycles after request; hit=1; data 16'hA0A1; mem_req never asserted.
3. Store 16'h1234 to 16'hF006, then load 16'h0A05 (same index, tag 0A) → 4 writes at F004..F007 with F006 carrying 16'h1234, then 4 reads at 0A04..0A07.
4. mem_ack delayed 5 cycles per word → addr_out and data_out_to_mem held stable; no word skipped or duplicated.
5. rst_n pulled low during REFILL word 2 → mem_req=0 at once, pro_ready=1; a later load of the same address misses again.
6. With CACHE_STATS_EN defined, after scenarios 1–3 → hit_count=2, miss_count=2.

Source files
------------

// File: rtl/cache_wb_dm.sv
// Direct-mapped write-back/write-allocate cache; optional hit/miss counters under `CACHE_STATS_EN`.
// Latency: a hit completes 2 cycles after accept; a miss adds one memory transfer per line word, or two lines if dirty.
// Backpressure: pro_ready is low while busy; each memory word holds its outputs until mem_ack.
module cache_wb_dm #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int INDEX_W  = 6,
   parameter int OFFSET_W = 2
) (
   input  logic              clk_100,
   input  logic              rst_n,
`ifdef CACHE_STATS_EN
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count,
`endif
   input  logic              pro_req,
   input  logic              pro_we,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [DATA_W-1:0] data_in_from_pro,
   output logic              pro_ready,
   output logic              pro_done,
   output logic [DATA_W-1:0] data_out_to_pro,
   output logic              hit,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] addr_out,
   output logic [DATA_W-1:0] data_out_to_mem,
   input  logic [DATA_W-1:0] data_in_from_mem,
   input  logic              mem_ack
);

   localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
   localparam int LINES = 1 << INDEX_W;
   localparam int WORDS_TOTAL = 1 << (INDEX_W + OFFSET_W);
   localparam logic [OFFSET_W-1:0] OFF0 = '0;

   typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;

   state_t                state;
   logic [TAG_W-1:0]      req_tag;
   logic [INDEX_W-1:0]    req_idx;
   logic [OFFSET_W-1:0]   req_off;
   logic                  req_we;
   logic [DATA_W-1:0]     req_data;
   logic [OFFSET_W-1:0]   cnt;
   logic [OFFSET_W-1:0]   cnt_nx;
   logic                  miss_flag;
   logic                  hit_flag;
   logic [LINES-1:0]      valid;
   logic [LINES-1:0]      dirty;

   logic [TAG_W-1:0]      tag_mem  [LINES];
   logic [DATA_W-1:0]     data_mem [WORDS_TOTAL];

   logic                  lookup_hit;
   logic                  last;
   logic                  xfer;
   logic [DATA_W-1:0]     rd_word;
   logic [TAG_W-1:0]      old_tag;
   logic                  arr_we;
   logic [INDEX_W+OFFSET_W-1:0] arr_addr;
   logic [DATA_W-1:0]     arr_wdata;
   logic                  tag_we;

   assign old_tag    = tag_mem[req_idx];
   assign lookup_hit = valid[req_idx] && (old_tag == req_tag);
   assign last       = &cnt;
   assign cnt_nx     = cnt + 1'b1;
   assign xfer       = mem_req && mem_ack;
   assign rd_word    = data_mem[{req_idx, req_off}];

   // Array writes: store hit in LOOKUP, or one refill word per acknowledged transfer.
   always_comb begin
      arr_we    = 1'b0;
      arr_addr  = {req_idx, req_off};
      arr_wdata = req_data;
      tag_we    = 1'b0;
      if (state == LOOKUP && lookup_hit && req_we) begin
         arr_we = 1'b1;
      end
      if (state == REFILL && xfer) begin
         arr_we    = 1'b1;
         arr_addr  = {req_idx, cnt};
         arr_wdata = data_in_from_mem;
         tag_we    = last;
      end
   end

   always_ff @(posedge clk_100) begin
      if (arr_we) data_mem[arr_addr] <= arr_wdata;
      if (tag_we) tag_mem[req_idx] <= req_tag;
   end

   always_ff @(posedge clk_100 or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         pro_ready       <= 1'b1;
         pro_done        <= 1'b0;
         hit             <= 1'b0;
         mem_req         <= 1'b0;
         mem_we          <= 1'b0;
         addr_out        <= '0;
         data_out_to_mem <= '0;
         data_out_to_pro <= '0;
         valid           <= '0;
         dirty           <= '0;
         cnt             <= '0;
         miss_flag       <= 1'b0;
         hit_flag        <= 1'b0;
         req_tag         <= '0;
         req_idx         <= '0;
         req_off         <= '0;
         req_we          <= 1'b0;
         req_data        <= '0;
      end else begin
         pro_done <= 1'b0;
         hit      <= 1'b0;
         case (state)
            IDLE: begin
               pro_ready <= 1'b1;
               if (pro_req) begin
                  {req_tag, req_idx, req_off} <= addr_in;
                  req_we    <= pro_we;
                  req_data  <= data_in_from_pro;
                  miss_flag <= 1'b0;
                  pro_ready <= 1'b0;
                  state     <= LOOKUP;
               end
            end
            LOOKUP: begin
               cnt <= '0;
               if (lookup_hit) begin
                  if (req_we) dirty[req_idx] <= 1'b1;
                  else        data_out_to_pro <= rd_word;
                  hit_flag <= ~miss_flag;
                  state    <= RESPOND;
               end else if (valid[req_idx] && dirty[req_idx]) begin
                  mem_req         <= 1'b1;
                  mem_we          <= 1'b1;
                  addr_out        <= {old_tag, req_idx, OFF0};
                  data_out_to_mem <= data_mem[{req_idx, OFF0}];
                  state           <= WRITEBACK;
               end else begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  addr_out <= {req_tag, req_idx, OFF0};
                  state    <= REFILL;
               end
            end
            WRITEBACK: begin
               if (xfer) begin
                  if (last) begin
                     dirty[req_idx] <= 1'b0;
                     cnt            <= '0;
                     mem_we         <= 1'b0;
                     addr_out       <= {req_tag, req_idx, OFF0};
                     state          <= REFILL;
                  end else begin
                     cnt             <= cnt_nx;
                     addr_out        <= {old_tag, req_idx, cnt_nx};
                     data_out_to_mem <= data_mem[{req_idx, cnt_nx}];
                  end
               end
            end
            REFILL: begin
               if (xfer) begin
                  if (last) begin
                     // Second lookup completes the access but must not report a hit.
                     valid[req_idx] <= 1'b1;
                     dirty[req_idx] <= 1'b0;
                     mem_req        <= 1'b0;
                     miss_flag      <= 1'b1;
                     cnt            <= '0;
                     state          <= LOOKUP;
                  end else begin
                     cnt      <= cnt_nx;
                     addr_out <= {req_tag, req_idx, cnt_nx};
                  end
               end
            end
            RESPOND: begin
               pro_done  <= 1'b1;
               hit       <= hit_flag;
               pro_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CACHE_STATS_EN
   always_ff @(posedge clk_100 or negedge rst_n) begin
      if (!rst_n) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (state == RESPOND) begin
         if (hit_flag) begin
            if (hit_count != '1) hit_count <= hit_count + 32'd1;
         end else begin
            if (miss_count != '1) miss_count <= miss_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cache_wb_dm.sv
// Scoreboarded random test of cache_wb_dm against a flat-memory reference and a line-residency model.
module tb_cache_wb_dm;

   logic        clk_100 = 1'b0;
   logic        rst_n = 1'b0;
   logic        pro_req = 1'b0;
   logic        pro_we = 1'b0;
   logic [15:0] addr_in = '0;
   logic [15:0] data_in_from_pro = '0;
   logic        pro_ready, pro_done, hit, mem_req, mem_we;
   logic [15:0] data_out_to_pro, addr_out, data_out_to_mem;
   logic [15:0] data_in_from_mem = '0;
   logic        mem_ack = 1'b0;
`ifdef CACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   always #5 clk_100 = ~clk_100;

   cache_wb_dm dut (
      .clk_100(clk_100), .rst_n(rst_n),
`ifdef CACHE_STATS_EN
      .hit_count(hit_count), .miss_count(miss_count),
`endif
      .pro_req(pro_req), .pro_we(pro_we), .addr_in(addr_in),
      .data_in_from_pro(data_in_from_pro), .pro_ready(pro_ready), .pro_done(pro_done),
      .data_out_to_pro(data_out_to_pro), .hit(hit), .mem_req(mem_req), .mem_we(mem_we),
      .addr_out(addr_out), .data_out_to_mem(data_out_to_mem),
      .data_in_from_mem(data_in_from_mem), .mem_ack(mem_ack)
   );

   typedef struct {logic chk_data; logic [15:0] data; logic hit; logic chk_lat; int lat;} resp_t;
   typedef struct {logic we; logic [15:0] addr; logic [15:0] data;} xfer_t;

   resp_t       resp_q[$];
   xfer_t       mem_q[$];
   logic [15:0] phys [65536];
   logic [15:0] arch [65536];
   logic        mvalid [64];
   logic        mdirty [64];
   logic [7:0]  mtag [64];
   int          nvec = 0, nfail = 0;
   int          cyc = 0, done_cnt = 0, req_cyc = 0;
   int          ack_mode = -1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk_100) cyc++;

   // Response monitor
   always @(negedge clk_100) begin
      resp_t r;
      if (rst_n && pro_done) begin
         if (resp_q.size() == 0) begin
            nvec++; nfail++;
            $display("FAIL unexpected_done: got pro_done=1 expected none");
         end else begin
            r = resp_q.pop_front();
            check("hit", hit, r.hit);
            if (r.chk_data) check("load_data", data_out_to_pro, r.data);
            if (r.chk_lat) check("hit_latency", cyc - req_cyc, r.lat);
         end
         done_cnt++;
      end
   end

   // Memory responder: random or fixed ack delay, checks every acknowledged word.
   logic        busy = 1'b0;
   int          wait_left = 0;
   logic [32:0] cap;
   always @(negedge clk_100) begin
      xfer_t x;
      if (mem_ack) begin mem_ack = 1'b0; busy = 1'b0; end
      if (!rst_n || !mem_req) busy = 1'b0;
      else begin
         if (!busy) begin
            busy = 1'b1;
            wait_left = (ack_mode < 0) ? int'($urandom_range(0, 3)) : ack_mode;
            cap = {mem_we, addr_out, data_out_to_mem};
         end
         if (wait_left == 0) begin
            check("mem_stable", {mem_we, addr_out, data_out_to_mem}, cap);
            if (mem_q.size() == 0) begin
               nvec++; nfail++;
               $display("FAIL unexpected_mem: got we=%0b addr %h expected no transfer", mem_we, addr_out);
            end else begin
               x = mem_q.pop_front();
               check("mem_we", mem_we, x.we);
               check("mem_addr", addr_out, x.addr);
               if (x.we) check("wb_data", data_out_to_mem, x.data);
            end
            if (mem_we) phys[addr_out] = data_out_to_mem;
            else data_in_from_mem = phys[addr_out];
            mem_ack = 1'b1;
         end else wait_left--;
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 64; i++) begin mvalid[i] = 1'b0; mdirty[i] = 1'b0; mtag[i] = '0; end
      for (int a = 0; a < 65536; a++) arch[a] = phys[a];
      resp_q.delete();
      mem_q.delete();
   endtask

   // Predict the access, then present it until accepted.
   task automatic issue(input logic we, input logic [15:0] a, input logic [15:0] d);
      resp_t r;
      xfer_t x;
      logic [5:0] idx;
      logic [7:0] tg;
      logic h;
      int t;
      idx = a[7:2];
      tg = a[15:8];
      h = mvalid[idx] && (mtag[idx] == tg);
      if (!h) begin
         if (mvalid[idx] && mdirty[idx])
            for (int w = 0; w < 4; w++) begin
               x.we = 1'b1; x.addr = {mtag[idx], idx, 2'(w)}; x.data = arch[x.addr];
               mem_q.push_back(x);
            end
         for (int w = 0; w < 4; w++) begin
            x.we = 1'b0; x.addr = {tg, idx, 2'(w)}; x.data = '0;
            mem_q.push_back(x);
         end
         mvalid[idx] = 1'b1; mtag[idx] = tg; mdirty[idx] = 1'b0;
      end
      if (we) begin arch[a] = d; mdirty[idx] = 1'b1; end
      r.chk_data = !we; r.data = arch[a]; r.hit = h; r.chk_lat = h; r.lat = 3;
      resp_q.push_back(r);
      @(negedge clk_100);
      t = 0;
      while (!pro_ready && t < 100) begin @(negedge clk_100); t++; end
      req_cyc = cyc;
      pro_req = 1'b1; pro_we = we; addr_in = a; data_in_from_pro = d;
      @(posedge clk_100);
      #1 pro_req = 1'b0;
   endtask

   task automatic access(input logic we, input logic [15:0] a, input logic [15:0] d);
      int s, t;
      s = done_cnt;
      issue(we, a, d);
      t = 0;
      while (done_cnt == s && t < 2000) begin @(negedge clk_100); #1; t++; end
      if (done_cnt == s) begin
         nvec++; nfail++;
         $display("FAIL done_timeout: got no pro_done for addr %h expected one", a);
      end
   endtask

   initial begin
      int t;
      for (int a = 0; a < 65536; a++) phys[a] = 16'(a * 37 + 11);
      for (int w = 0; w < 4; w++) phys[16'hF004 + w] = 16'(16'hA0A0 + w);
      model_reset();
      repeat (3) @(negedge clk_100);
      rst_n = 1'b1;
      @(negedge clk_100);
      check("rst_pro_ready", pro_ready, 1'b1);
      check("rst_pro_done", pro_done, 1'b0);
      check("rst_hit", hit, 1'b0);
      check("rst_mem_req", {mem_req, mem_we}, 2'b00);
      check("rst_addr_out", addr_out, 16'h0000);
      check("rst_data_out", {data_out_to_mem, data_out_to_pro}, 32'h0);

      access(1'b0, 16'hF005, 16'h0);        // cold miss, expects A0A1
      access(1'b0, 16'hF005, 16'h0);        // hit
      access(1'b1, 16'hF006, 16'h1234);     // store hit -> dirty
      access(1'b0, 16'h0A05, 16'h0);        // conflict: write-back then refill
`ifdef CACHE_STATS_EN
      check("hit_count", hit_count, 32'd2);
      check("miss_count", miss_count, 32'd2);
`endif

      ack_mode = 5;
      access(1'b1, 16'h0A07, 16'hBEEF);
      access(1'b0, 16'hF005, 16'h0);
      ack_mode = -1;

      // Reset while the third refill word is outstanding.
      ack_mode = 3;
      issue(1'b0, 16'h1234, 16'h0);
      t = 0;
      while (!(mem_req && !mem_we && addr_out == 16'h1236) && t < 200) begin @(negedge clk_100); t++; end
      check("mid_refill_reached", {mem_req, addr_out}, {1'b1, 16'h1236});
      @(posedge clk_100);
      #2 rst_n = 1'b0;
      #1;
      check("abort_mem_req", mem_req, 1'b0);
      check("abort_pro_ready", pro_ready, 1'b1);
      model_reset();
      repeat (2) @(negedge clk_100);
      rst_n = 1'b1;
      ack_mode = -1;
      access(1'b0, 16'h1234, 16'h0);        // must miss again

      for (int n = 0; n < 300; n++) begin
         logic [15:0] a;
         logic [7:0] tg;
         tg = 8'(8'h10 * (($urandom % 4) + 1));
         a = {tg, 4'h0, 2'($urandom % 4), 2'($urandom % 4)};
         access(1'($urandom % 2), a, 16'($urandom));
      end

      check("resp_q_drained", resp_q.size(), 0);
      check("mem_q_drained", mem_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
